// File: rtl/alu_pkg.sv
// Shared opcode encodings and helpers for the registered 8-bit ALU.
// Imported by alu_op_unit and alu_core.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_FWD = 3'b000;
    localparam alu_op_t ALU_ADD = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;
    localparam alu_op_t ALU_OR  = 3'b011;

    localparam int ALU_WIDTH = 8;

    // Codes 100-111 are reserved; only the low half of the space is defined.
    function automatic logic alu_op_defined(alu_op_t op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_op_unit.sv
// Combinational ALU datapath: computes FWD/ADD/AND/OR in parallel and selects one.
// Reserved opcodes select the caller's current result so nothing undefined leaks out.
module alu_op_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  alu_op_t          select,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] result,
    output logic             op_valid
);

    logic [WIDTH-1:0] fwd_res;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] and_res;
    logic [WIDTH-1:0] or_res;

    // Carry out of the adder is intentionally dropped.
    assign fwd_res = data2;
    assign add_res = data1 + data2;
    assign and_res = data1 & data2;
    assign or_res  = data1 | data2;

    assign op_valid = alu_op_defined(select);

    always_comb begin
        result = cur;
        case (select)
            ALU_FWD: result = fwd_res;
            ALU_ADD: result = add_res;
            ALU_AND: result = and_res;
            ALU_OR:  result = or_res;
            default: result = cur;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// Registered 8-bit ALU with one-cycle valid handshake and async active-low reset.
// Optional registered ZERO flag when ALU_ZERO_FLAG_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    output logic [WIDTH-1:0] RESULT,
    output logic             OUT_VALID
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic             ZERO
`endif
);

    logic [WIDTH-1:0] next_result;
    logic             op_valid;
    logic             load;

    alu_op_unit #(
        .WIDTH    (WIDTH)
    ) u_op (
        .data1    (DATA1),
        .data2    (DATA2),
        .select   (SELECT),
        .cur      (RESULT),
        .result   (next_result),
        .op_valid (op_valid)
    );

    // Reserved opcodes still complete the handshake but leave RESULT alone.
    assign load = IN_VALID && op_valid;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RESULT    <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= IN_VALID;
            if (load) begin
                RESULT <= next_result;
            end
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ZERO <= 1'b1;
        end else if (load) begin
            ZERO <= (next_result == '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core.
// Build with +define+ALU_ZERO_FLAG_EN to also check the ZERO flag.
`timescale 1ns/1ps
module tb_alu_core;

    logic       CLK;
    logic       RESET_N;
    logic       IN_VALID;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [2:0] SELECT;
    logic [7:0] RESULT;
    logic       OUT_VALID;
`ifdef ALU_ZERO_FLAG_EN
    logic       ZERO;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_core dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_VALID  (IN_VALID),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .SELECT    (SELECT),
        .RESULT    (RESULT),
        .OUT_VALID (OUT_VALID)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .ZERO      (ZERO)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] sel,
                         input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK);
        IN_VALID = v;
        SELECT   = sel;
        DATA1    = a;
        DATA2    = b;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_res,
                             input logic exp_vld, input logic exp_zero);
        chk({tag, "_result"}, RESULT, exp_res);
        chk({tag, "_valid"}, {7'd0, OUT_VALID}, {7'd0, exp_vld});
`ifdef ALU_ZERO_FLAG_EN
        chk({tag, "_zero"}, {7'd0, ZERO}, {7'd0, exp_zero});
`else
        if (exp_zero) begin end
`endif
    endtask

    task automatic apply(input string tag, input logic [2:0] sel,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_res, input logic exp_zero);
        drive(1'b1, sel, a, b);
        tick();
        check_out(tag, exp_res, 1'b1, exp_zero);
    endtask

    initial begin
        RESET_N  = 1'b1;
        IN_VALID = 1'b0;
        SELECT   = 3'b000;
        DATA1    = 8'd0;
        DATA2    = 8'd0;

        // asynchronous reset between edges
        #2;
        RESET_N = 1'b0;
        #1;
        check_out("rst_async", 8'd0, 1'b0, 1'b1);
        tick();
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        tick();
        check_out("rst_hold", 8'd0, 1'b0, 1'b1);

        apply("fwd_25_41",   3'b000, 8'd25,  8'd41,  8'd41,  1'b0);
        apply("add_152_23",  3'b001, 8'd152, 8'd23,  8'd175, 1'b0);
        apply("add_27_74",   3'b001, 8'd27,  8'd74,  8'd101, 1'b0);
        apply("add_222_22",  3'b001, 8'd222, 8'd22,  8'd244, 1'b0);
        apply("add_wrap",    3'b001, 8'd200, 8'd100, 8'd44,  1'b0);

        apply("and_96_4",    3'b010, 8'd96,  8'd4,   8'd0,   1'b1);
        apply("or_14_14",    3'b011, 8'd14,  8'd14,  8'd14,  1'b0);

        apply("rsv_100",     3'b100, 8'd1,   8'd2,   8'd14,  1'b0);
        apply("rsv_101",     3'b101, 8'd255, 8'd255, 8'd14,  1'b0);

        drive(1'b0, 3'b001, 8'd9, 8'd9);
        tick();
        check_out("idle_a", 8'd14, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 8'd0, 8'd0);
        tick();
        check_out("idle_b", 8'd14, 1'b0, 1'b0);

        apply("and_53_64",   3'b010, 8'd53,  8'd64,  8'd0,   1'b1);
        apply("or_53_64",    3'b011, 8'd53,  8'd64,  8'd117, 1'b0);

        // three back-to-back ops, one result per cycle
        drive(1'b1, 3'b001, 8'd1, 8'd2);
        tick();
        check_out("b2b_0", 8'd3, 1'b1, 1'b0);
        drive(1'b1, 3'b011, 8'd240, 8'd15);
        tick();
        check_out("b2b_1", 8'd255, 1'b1, 1'b0);
        drive(1'b1, 3'b000, 8'd77, 8'd0);
        tick();
        check_out("b2b_2", 8'd0, 1'b1, 1'b1);
        drive(1'b0, 3'b001, 8'd5, 8'd6);
        tick();
        check_out("b2b_end", 8'd0, 1'b0, 1'b1);

        // reset while an op is presented discards it
        apply("pre_rst", 3'b001, 8'd10, 8'd20, 8'd30, 1'b0);
        drive(1'b1, 3'b001, 8'd5, 8'd5);
        #2;
        RESET_N = 1'b0;
        #1;
        check_out("rst_mid", 8'd0, 1'b0, 1'b1);
        tick();
        check_out("rst_mid_edge", 8'd0, 1'b0, 1'b1);
        drive(1'b0, 3'b000, 8'd0, 8'd0);
        RESET_N = 1'b1;
        tick();
        check_out("rst_release", 8'd0, 1'b0, 1'b1);
        apply("post_rst", 3'b001, 8'd5, 8'd5, 8'd10, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
